// File: rtl/window_7x7_builder.sv
// window_7x7_builder
//   Consumer end of the 7-row line-buffer chain. Each accepted cycle it
//   shifts the vertical column {taps6..taps1, din} into a 7x7 register
//   window and tracks the column/row of the accepted pixel. win_valid is a
//   one-cycle strobe that marks windows whose 49 pixels all lie in-frame.
//   frame_done pulses after the last pixel of a frame.
//
//   Optional feature macro: WIN_POS_OUT_EN adds the registered window-centre
//   outputs cx/cy. These hold their value between valid strobes.
//
//   Window layout: byte 7*i+j is row i and column j. Row 0 is the oldest row
//   (taps6) and row 6 is din. Column 0 is the oldest column and column 6 is
//   the newest. Byte k occupies win[8k+7:8k].

module window_7x7_builder #(
  parameter int WIDTH  = 577,
  parameter int HEIGHT = 480
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         sof,
  input  logic [7:0]   din,
  input  logic [7:0]   taps1,
  input  logic [7:0]   taps2,
  input  logic [7:0]   taps3,
  input  logic [7:0]   taps4,
  input  logic [7:0]   taps5,
  input  logic [7:0]   taps6,
  output logic [391:0] win,
  output logic         win_valid,
  output logic         frame_done
`ifdef WIN_POS_OUT_EN
  ,
  output logic [9:0]   cx,
  output logic [9:0]   cy
`endif
);

  localparam int            MAX_DIM  = (WIDTH > HEIGHT) ? WIDTH : HEIGHT;
  localparam int            CW       = $clog2(MAX_DIM);
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ROW_LAST = CW'(HEIGHT - 1);
  localparam logic [CW-1:0] MARGIN   = CW'(6);

  // Position of the next pixel to be accepted.
  logic [CW-1:0] col;
  logic [CW-1:0] row;

  // Effective position of the pixel on the inputs this cycle (sof resyncs it).
  logic [CW-1:0] pos_col;
  logic [CW-1:0] pos_row;
  logic [CW-1:0] col_nxt;
  logic [CW-1:0] row_nxt;
  logic          pos_col_last;
  logic          pos_frame_last;
  logic          pos_in_frame;

  logic [7:0] new_col [7];
  logic [7:0] pix     [7][7];

  // Resolve this pixel's position and the counter values that follow it.
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch, so
    // no path can leave a signal unassigned and infer a latch.
    pos_col        = '0;
    pos_row        = '0;
    col_nxt        = '0;
    row_nxt        = '0;
    pos_col_last   = 1'b0;
    pos_frame_last = 1'b0;
    pos_in_frame   = 1'b0;

    if (!sof) begin
      pos_col = col;
      pos_row = row;
    end

    pos_col_last   = (pos_col == COL_LAST);
    pos_frame_last = pos_col_last && (pos_row == ROW_LAST);
    // Columns 0..5 would straddle the previous line, and rows 0..5 would
    // reach above the top of the frame.
    pos_in_frame   = (pos_col >= MARGIN) && (pos_row >= MARGIN);

    col_nxt = pos_col_last ? '0 : pos_col + CW'(1);
    row_nxt = pos_row;
    if (pos_col_last) begin
      row_nxt = (pos_row == ROW_LAST) ? '0 : pos_row + CW'(1);
    end
  end

  // Assemble the incoming column from oldest row (taps6) to newest (din).
  always_comb begin
    new_col[0] = taps6;
    new_col[1] = taps5;
    new_col[2] = taps4;
    new_col[3] = taps3;
    new_col[4] = taps2;
    new_col[5] = taps1;
    new_col[6] = din;
  end

  // Counters, strobes and the window shift register.
  always_ff @(posedge clk) begin
    // NOTE: state is written with non-blocking assignments only. Every
    // register then samples the pre-edge values, whatever the statement order.
    if (!rst_n) begin
      col        <= '0;
      row        <= '0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      // NOTE: the window array is reset on purpose, because a reset must
      // present an all-zero win. Plain data arrays normally skip reset.
      for (int i = 0; i < 7; i++) begin
        for (int j = 0; j < 7; j++) begin
          pix[i][j] <= '0;
        end
      end
    end else begin
      win_valid  <= en && pos_in_frame;
      frame_done <= en && pos_frame_last;
      if (en) begin
        col <= col_nxt;
        row <= row_nxt;
        for (int i = 0; i < 7; i++) begin
          for (int j = 0; j < 6; j++) begin
            pix[i][j] <= pix[i][j+1];
          end
          pix[i][6] <= new_col[i];
        end
      end
    end
  end

`ifdef WIN_POS_OUT_EN
  // Centre of the completed window, captured only when it is valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cx <= '0;
      cy <= '0;
    end else if (en && pos_in_frame) begin
      cx <= 10'(pos_col) - 10'd3;
      cy <= 10'(pos_row) - 10'd3;
    end
  end
`endif

  // Flatten the window into the output bus.
  always_comb begin
    win = '0;
    for (int i = 0; i < 7; i++) begin
      for (int j = 0; j < 7; j++) begin
        win[8*(7*i+j) +: 8] = pix[i][j];
      end
    end
  end

endmodule

// File: tb/tb_window_7x7_builder.sv
// Directed bench for window_7x7_builder on a 16x12 frame.
// Pixel value is row*16+col (mod 256). Each tap carries the same column from
// the row k lines above. Expected values come from that formula and from
// hand-computed constants.

module tb_window_7x7_builder;

  localparam int W = 16;
  localparam int H = 12;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic         sof;
  logic [7:0]   din;
  logic [7:0]   taps1, taps2, taps3, taps4, taps5, taps6;
  logic [391:0] win;
  logic         win_valid;
  logic         frame_done;
`ifdef WIN_POS_OUT_EN
  logic [9:0]   cx;
  logic [9:0]   cy;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  window_7x7_builder #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .sof        (sof),
    .din        (din),
    .taps1      (taps1),
    .taps2      (taps2),
    .taps3      (taps3),
    .taps4      (taps4),
    .taps5      (taps5),
    .taps6      (taps6),
    .win        (win),
    .win_valid  (win_valid),
    .frame_done (frame_done)
`ifdef WIN_POS_OUT_EN
    ,
    .cx         (cx),
    .cy         (cy)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic logic [7:0] pix(input int r, input int c);
    return 8'(r * W + c);
  endfunction

  // Present one cycle of inputs, then sample the outputs 1 time unit after the edge.
  task automatic drive(input logic e, input logic s, input int r, input int c);
    en    = e;
    sof   = s;
    din   = pix(r, c);
    taps1 = pix(r - 1, c);
    taps2 = pix(r - 2, c);
    taps3 = pix(r - 3, c);
    taps4 = pix(r - 4, c);
    taps5 = pix(r - 5, c);
    taps6 = pix(r - 6, c);
    @(posedge clk);
    #1;
  endtask

  // Stream pixels 0..n_pix-1 of a frame. In toggle mode an idle cycle
  // precedes every pixel. Per-cycle mismatches are counted in errs.
  task automatic run_frame(input bit first_sof, input bit toggle, input int n_pix,
                           output int vcnt, output int first_v, output int fdcnt,
                           output int errs);
    logic [391:0] held;
    vcnt    = 0;
    first_v = -1;
    fdcnt   = 0;
    errs    = 0;
    for (int idx = 0; idx < n_pix; idx++) begin
      int r;
      int c;
      r = idx / W;
      c = idx % W;
      if (toggle) begin
        held = win;
        drive(1'b0, 1'b0, int'($urandom_range(0, 11)), int'($urandom_range(0, 15)));
        if (win_valid !== 1'b0 || frame_done !== 1'b0 || win !== held) errs++;
      end
      drive(1'b1, first_sof && (idx == 0), r, c);
      if (win_valid === 1'b1) begin
        vcnt++;
        if (first_v < 0) first_v = idx;
      end
      if (frame_done === 1'b1) fdcnt++;
      if (win_valid !== (r >= 6 && c >= 6)) errs++;
      if (frame_done !== (idx == W * H - 1)) errs++;
      if (r >= 6 && c >= 6) begin
        for (int i = 0; i < 7; i++) begin
          for (int j = 0; j < 7; j++) begin
            if (win[8*(7*i+j) +: 8] !== pix(r - 6 + i, c - 6 + j)) errs++;
          end
        end
      end
      if (r == 8 && c == 9) begin
        check("win_b0_r8c9",  64'(win[7:0]),     64'd35);
        check("win_b24_r8c9", 64'(win[199:192]), 64'd86);
        check("win_b48_r8c9", 64'(win[391:384]), 64'd137);
`ifdef WIN_POS_OUT_EN
        check("cx_r8c9", 64'(cx), 64'd6);
        check("cy_r8c9", 64'(cy), 64'd5);
`endif
      end
    end
  endtask

  task automatic frame_checks(input string tag, input int vcnt, input int first_v,
                              input int fdcnt, input int errs, input int exp_v,
                              input int exp_first, input int exp_fd);
    check({tag, "_valid_count"}, 64'(vcnt),    64'(exp_v));
    check({tag, "_first_valid"}, 64'(first_v), 64'(exp_first));
    check({tag, "_frame_done"},  64'(fdcnt),   64'(exp_fd));
    check({tag, "_cycle_errs"},  64'(errs),    64'd0);
  endtask

  initial begin
    int vcnt;
    int first_v;
    int fdcnt;
    int errs;

    // Reset held with en high: both pixels are discarded and the outputs stay zero.
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 0, 5);
    drive(1'b1, 1'b0, 0, 6);
    check("rst_win_valid",  64'(win_valid),  64'd0);
    check("rst_frame_done", 64'(frame_done), 64'd0);
    check("rst_win_zero",   64'(|win),       64'd0);
`ifdef WIN_POS_OUT_EN
    check("rst_cx", 64'(cx), 64'd0);
    check("rst_cy", 64'(cy), 64'd0);
`endif
    rst_n = 1'b1;

    // No sof here: the counters must already be at (0,0) after reset.
    run_frame(1'b0, 1'b0, W * H, vcnt, first_v, fdcnt, errs);
    frame_checks("post_rst", vcnt, first_v, fdcnt, errs, 60, 102, 1);

    // Continuous frame with sof on its first pixel.
    run_frame(1'b1, 1'b0, W * H, vcnt, first_v, fdcnt, errs);
    frame_checks("cont", vcnt, first_v, fdcnt, errs, 60, 102, 1);

    // en toggles every cycle: idle cycles hold the window and drop the strobes.
    run_frame(1'b1, 1'b1, W * H, vcnt, first_v, fdcnt, errs);
    frame_checks("toggle", vcnt, first_v, fdcnt, errs, 60, 102, 1);

    // Abort after 50 pixels, then resync with sof.
    run_frame(1'b1, 1'b0, 50, vcnt, first_v, fdcnt, errs);
    frame_checks("abort", vcnt, first_v, fdcnt, errs, 0, -1, 0);
    run_frame(1'b1, 1'b0, W * H, vcnt, first_v, fdcnt, errs);
    frame_checks("resync", vcnt, first_v, fdcnt, errs, 60, 102, 1);

    // Stream up to and including pixel (row 7, col 10), then pulse reset.
    run_frame(1'b1, 1'b0, 7 * W + 11, vcnt, first_v, fdcnt, errs);
    check("pre_rst_valid", 64'(win_valid), 64'd1);
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 0, 0);
    check("midrst_win_valid",  64'(win_valid),  64'd0);
    check("midrst_frame_done", 64'(frame_done), 64'd0);
    check("midrst_win_zero",   64'(|win),       64'd0);
`ifdef WIN_POS_OUT_EN
    check("midrst_cx", 64'(cx), 64'd0);
    check("midrst_cy", 64'(cy), 64'd0);
`endif
    rst_n = 1'b1;
    run_frame(1'b0, 1'b0, W * H, vcnt, first_v, fdcnt, errs);
    frame_checks("after_midrst", vcnt, first_v, fdcnt, errs, 60, 102, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/window_7x7_builder.md
# window_7x7_builder

Consumer end of the 7-row line-buffer chain in the ORB front end. Takes the live pixel plus six vertically aligned line-buffer taps each accepted cycle, shifts them into a 7×7 register window, and tracks column/row position. Emits a flattened window with a valid strobe only when all 49 pixels lie inside the current frame. Sits between the line-buffer chain and the FAST/BRIEF stages.

## Interface
- WIDTH, 577: pixels per line; must equal the line-buffer depth feeding taps.
- HEIGHT, 480: lines per frame.
- clk  in  1: clock; all logic on rising edge.
- rst_n  in  1: synchronous, active-low reset.
- en  in  1: pixel-accept strobe, same `en` that drives the line buffers.
- sof  in  1: start of frame, qualified by `en`; marks pixel (0,0).
- din  in  8: current pixel, row r.
- taps1 … taps6  in  8 each: pixels from rows r-1 … r-6, same column.
- win  out  392: window; byte index 7*i+j = row i (0 = oldest, taps6) and column j (0 = oldest, 6 = newest); bits [8k+7:8k] hold byte k.
- win_valid  out  1: `win` holds a fully in-frame window.
- frame_done  out  1: one-cycle pulse after the last pixel of a frame.
- cx  out  10, cy  out  10: window centre coordinates. Present only with WIN_POS_OUT_EN.

## Operation
- Column load on `en`: the new column is {taps6,…,taps1,din}. Window columns shift toward j=0, and the new column enters at j=6. When `en` is low, the window, counters and outputs hold, except the strobes.
- Counters `col` (0..WIDTH-1) and `row` (0..HEIGHT-1) hold the position of the pixel being accepted.
  - On `en`: `col` increments.
  - At WIDTH-1: `col` wraps to 0 and `row` increments.
  - At (WIDTH-1, HEIGHT-1): both wrap to 0.
- `sof` handling: `en && sof` forces that pixel's position to (0,0), so the counters go to col=1, row=0 after it. This overrides any mid-frame count (resync). A pending `frame_done` is not generated for the aborted frame.
- Window validity: a window is in-frame when the accepted pixel has col≥6 and row≥6. Windows that straddle a line boundary (col<6) are never flagged valid.
- Valid windows per frame: (WIDTH-6)·(HEIGHT-6).
- `frame_done` is set on the cycle after accepting pixel (WIDTH-1, HEIGHT-1).
- Counter width: ceil(log2(max(WIDTH,HEIGHT))). Comparisons are unsigned.

## Timing
- Reset (rst_n low at an edge): win=0, win_valid=0, frame_done=0, col=0, row=0, cx=cy=0. This holds even mid-frame; the next accepted pixel is treated as (0,0).
- Latency: 1 cycle. Pixel accepted at edge N; `win` and `win_valid` update at edge N+1.
- `win_valid` and `frame_done` are single-cycle strobes. They deassert on any cycle without `en`, or after an accepted pixel that is not a valid position.
- Back-to-back `en` produces back-to-back valid windows along a line.
- Reset asserted together with `en`: reset wins and the pixel is discarded.

## Configuration
- WIN_POS_OUT_EN defined:
  - `cx`/`cy` are registered alongside `win_valid`.
  - cx = col-3 and cy = row-3 of the completing pixel.
  - Both hold their values between valid strobes.
- WIN_POS_OUT_EN undefined: the ports and their registers are absent; all other behaviour is identical.

## Test plan
- WIDTH=16, HEIGHT=12; reset, then stream 192 pixels with `en` continuously high and `sof` on the first → first `win_valid` at the cycle after pixel index 102 (col 6, row 6). Exactly 60 valid strobes. `frame_done` fires once, after pixel 191.
- din=row·16+col and taps consistent with rows r-1..r-6 → at pixel (9,8) `win` byte 0 = row 2 col 3 (value 35) and byte 48 = row 8 col 9 (value 137). With WIN_POS_OUT_EN: cx=6, cy=5.
- `en` toggled 1/0 every cycle → the valid count is still 60 per frame. `win_valid` is never high on the cycle following an `en`=0 cycle.
- `sof` reasserted at pixel 50 of a frame → counters resync. No `frame_done` for the aborted frame; the next valid strobe comes 103 pixels after the resync.
- rst_n pulsed low mid-line (at row 7, col 10) → all outputs 0 next cycle. After release, the first `win_valid` needs 103 further accepted pixels.
- Reset and `en` asserted in the same cycle → that pixel is ignored and col=0 afterwards.
